// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris input conditioner.
// Provides the move-command bit positions, the lane numbering used by
// the top level, the 4-bit command vector type and a fixed-priority
// pick helper (lowest set bit wins: Left > Right > Down > Rotate).
package tetris_pkg;

  localparam int unsigned CMD_LEFT   = 0;
  localparam int unsigned CMD_RIGHT  = 1;
  localparam int unsigned CMD_DOWN   = 2;
  localparam int unsigned CMD_ROTATE = 3;
  localparam int unsigned NUM_CMDS   = 4;

  // Lanes 0..3 carry the move commands in CMD_* order.
  localparam int unsigned LANE_START     = 4;
  localparam int unsigned LANE_TRY_AGAIN = 5;
  localparam int unsigned NUM_LANES      = 6;

  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  // One-hot grant of the highest-priority request (lowest index).
  function automatic cmd_vec_t cmd_priority_pick(input cmd_vec_t req);
    cmd_vec_t grant;
    grant = '0;
    for (int unsigned i = 0; i < NUM_CMDS; i++) begin
      if (req[i] && (grant == '0)) begin
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/tetris_button_lane.sv
// One push-button lane: 2-flop synchroniser, counter debounce, rising-edge
// event and optional auto-repeat.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : raw asynchronous button, active-high
//   level_o    : debounced level
//   event_o    : one-cycle strobe on each press and, with REPEAT_EN, on
//                every repeat while held; high in the first cycle the
//                debounced level is 1 (and on each repeat cycle)
module tetris_button_lane
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned CNT_W           = 16,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic event_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d, db_cnt_inc;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_cnt_inc, rep_target;
  logic             rep_first_q, rep_first_d;
  logic             rep_fire;
  logic             event_q, event_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      event_q     <= event_d;
    end
  end

  // Debounce: count consecutive cycles of disagreement; any agreement clears.
  always_comb begin
    level_d    = level_q;
    db_cnt_d   = '0;
    db_cnt_inc = db_cnt_q + 1'b1;
    if (sync2_q != level_q) begin
      if (db_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_inc;
      end
    end
  end

  // Auto-repeat: rep_cnt_q holds cycles since the press (or last repeat).
  // rep_first_q selects REPEAT_RATE once the initial REPEAT_DELAY has fired.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b0;
    rep_fire    = 1'b0;
    rep_cnt_inc = rep_cnt_q + 1'b1;
    rep_target  = rep_first_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
    if (REPEAT_EN && level_q && level_d) begin
      rep_cnt_d   = rep_cnt_inc;
      rep_first_d = rep_first_q;
      if (rep_cnt_inc == rep_target) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end
    end
  end

  assign event_d = (level_d & ~level_q) | rep_fire;

  assign level_o = level_q;
  assign event_o = event_q;

endmodule

// File: rtl/tetris_input_conditioner.sv
// Button front end for the tetris1 core.
// Six conditioned button lanes feed a pending-move register. Moves are
// issued one at a time, highest priority first (Left > Right > Down >
// Rotate), only while core_ready is high, with an idle cycle after each
// issue. Start and try_again are forwarded as ungated one-cycle pulses.
// Ports:
//   Clk, Reset_n           : clock, asynchronous active-low reset
//   btn_*                  : raw asynchronous buttons, active-high
//   core_ready             : core currently accepts moves
//   Left/Right/Down/Rotate : one-cycle move pulses, mutually exclusive
//   Start, try_again       : one-cycle pulses
//   pending                : queued moves {Rotate, Down, Right, Left}
module tetris_input_conditioner
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_rotate,
  input  logic       btn_start,
  input  logic       btn_try_again,
  input  logic       core_ready,
  output logic       Left,
  output logic       Right,
  output logic       Down,
  output logic       Rotate,
  output logic       Start,
  output logic       try_again,
  output logic [3:0] pending
);

  logic [NUM_LANES-1:0] btn_raw;
  logic [NUM_LANES-1:0] lane_event;
  // Debounced levels are not needed here; only the event strobes are.
  logic [NUM_LANES-1:0] lane_level_unused;
  cmd_vec_t             move_ev;

  cmd_vec_t pending_q, pending_d;
  cmd_vec_t move_q, move_d;
  logic     gap_q, gap_d;
  logic     start_q, start_d;
  logic     try_again_q, try_again_d;

  assign btn_raw = {btn_try_again, btn_start, btn_rotate, btn_down, btn_right, btn_left};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tetris_button_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W),
      .REPEAT_EN      (g <= CMD_DOWN)
    ) u_lane (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .btn_i  (btn_raw[g]),
      .level_o(lane_level_unused[g]),
      .event_o(lane_event[g])
    );
  end

  assign move_ev = lane_event[NUM_CMDS-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q   <= '0;
      move_q      <= '0;
      gap_q       <= 1'b0;
      start_q     <= 1'b0;
      try_again_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      move_q      <= move_d;
      gap_q       <= gap_d;
      start_q     <= start_d;
      try_again_q <= try_again_d;
    end
  end

  // Issue clears are applied before new events so a same-cycle event
  // re-arms the bit being issued.
  always_comb begin
    move_d = '0;
    if (core_ready && !gap_q && (pending_q != '0)) begin
      move_d = cmd_priority_pick(pending_q);
    end
    gap_d     = |move_d;
    pending_d = pending_q & ~move_d;

    if (move_ev[CMD_LEFT] && move_ev[CMD_RIGHT]) begin
      pending_d[CMD_LEFT]  = 1'b0;
      pending_d[CMD_RIGHT] = 1'b0;
    end else if (move_ev[CMD_LEFT]) begin
      pending_d[CMD_LEFT]  = 1'b1;
      pending_d[CMD_RIGHT] = 1'b0;
    end else if (move_ev[CMD_RIGHT]) begin
      pending_d[CMD_RIGHT] = 1'b1;
      pending_d[CMD_LEFT]  = 1'b0;
    end
    if (move_ev[CMD_DOWN]) begin
      pending_d[CMD_DOWN] = 1'b1;
    end
    if (move_ev[CMD_ROTATE]) begin
      pending_d[CMD_ROTATE] = 1'b1;
    end

    start_d     = lane_event[LANE_START];
    try_again_d = lane_event[LANE_TRY_AGAIN];
  end

  assign Left      = move_q[CMD_LEFT];
  assign Right     = move_q[CMD_RIGHT];
  assign Down      = move_q[CMD_DOWN];
  assign Rotate    = move_q[CMD_ROTATE];
  assign Start     = start_q;
  assign try_again = try_again_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Self-checking bench for tetris_input_conditioner: directed scenarios plus
// randomized button traffic against a cycle-stepped behavioural model.
module tb_tetris_input_conditioner;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic btn_rotate = 1'b0, btn_start = 1'b0, btn_try_again = 1'b0;
  logic core_ready = 1'b0;
  logic Left, Right, Down, Rotate, Start, try_again;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;

  tetris_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (16)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_down     (btn_down),
    .btn_rotate   (btn_rotate),
    .btn_start    (btn_start),
    .btn_try_again(btn_try_again),
    .core_ready   (core_ready),
    .Left         (Left),
    .Right        (Right),
    .Down         (Down),
    .Rotate       (Rotate),
    .Start        (Start),
    .try_again    (try_again),
    .pending      (pending)
  );

  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  // Lane i: raw button seen two cycles late; level flips once the last DB
  // synchronised samples all disagree with it; events at press age 0 and,
  // for moves, at ages RD, RD+RR, RD+2RR, ...
  logic [5:0]    m_s1, m_s2, m_lvl, m_ev;
  logic [DB-1:0] m_win [6];
  int            m_age [6];
  logic [3:0]    m_pend, m_move;
  logic          m_gap, m_start, m_try;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_ev = '0;
    for (int i = 0; i < 6; i++) begin
      m_win[i] = '0;
      m_age[i] = 0;
    end
    m_pend = '0; m_move = '0; m_gap = 1'b0; m_start = 1'b0; m_try = 1'b0;
  endtask

  task automatic model_step();
    logic [5:0] raw, nl, ne;
    logic [3:0] grant, p;
    raw = {btn_try_again, btn_start, btn_rotate, btn_down, btn_right, btn_left};
    if (!Reset_n) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 6; i++) begin
      m_win[i] = {m_win[i][DB-2:0], m_s2[i]};
      nl[i] = (m_win[i] == {DB{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
      if (nl[i] && !m_lvl[i]) m_age[i] = 0;
      else if (nl[i])         m_age[i] = m_age[i] + 1;
      else                    m_age[i] = 0;
      ne[i] = nl[i] && (m_age[i] == 0 ||
                        (i < 3 && m_age[i] >= RD && (m_age[i] - RD) % RR == 0));
    end
    grant = '0;
    if (core_ready && !m_gap) begin
      for (int b = 0; b < 4; b++) begin
        if (m_pend[b]) begin
          grant[b] = 1'b1;
          break;
        end
      end
    end
    p = m_pend & ~grant;
    if (m_ev[0]) p[1] = 1'b0;
    if (m_ev[1]) p[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (m_ev[b] && !(b < 2 && m_ev[0] && m_ev[1])) p[b] = 1'b1;
    end
    m_start = m_ev[4];
    m_try   = m_ev[5];
    m_move  = grant;
    m_gap   = |grant;
    m_pend  = p;
    m_s2    = m_s1;
    m_s1    = raw;
    m_lvl   = nl;
    m_ev    = ne;
  endtask

  // Advance one clock; leaves the caller just after the falling edge.
  task automatic step();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  function automatic logic [9:0] obs_vec();
    return {Left, Right, Down, Rotate, Start, try_again, pending};
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_move[0], m_move[1], m_move[2], m_move[3], m_start, m_try, m_pend};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int pulses;
    model_clear();
    Reset_n = 1'b0; core_ready = 1'b1; btn_left = 1'b1;
    repeat (3) step();
    checks++;
    if (obs_vec() !== 10'b0) begin
      errors++; $display("FAIL reset_hold: got %b want %b", obs_vec(), 10'b0);
    end
    btn_left = 1'b0;
    Reset_n = 1'b1;
    step();
    checks++;
    if (obs_vec() !== 10'b0) begin
      errors++; $display("FAIL reset_first_edge: got %b want %b", obs_vec(), 10'b0);
    end
    // queue a Down, then reset mid-operation with core_ready high
    core_ready = 1'b0; btn_down = 1'b1;
    for (int k = 0; k < 30 && pending !== 4'b0100; k++) step();
    checks++;
    if (pending !== 4'b0100) begin
      errors++; $display("FAIL reset_preload: got %b want %b", pending, 4'b0100);
    end
    core_ready = 1'b1; Reset_n = 1'b0; btn_down = 1'b0;
    model_clear();
    #1;
    checks++;
    if (obs_vec() !== 10'b0) begin
      errors++; $display("FAIL reset_async: got %b want %b", obs_vec(), 10'b0);
    end
    step(); step();
    Reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      pulses += int'(Left) + int'(Right) + int'(Down) + int'(Rotate) + int'(pending != 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release_cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_no_pulse: got %0d want 0", pulses);
    end
  endtask

  task automatic test_bounce();
    int cnt, at;
    core_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      btn_left = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      btn_left = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
    cnt = 0; at = -1;
    btn_left = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (Left) begin
        cnt++;
        if (at < 0) at = k;
      end
    end
    checks++;
    if (cnt !== 1) begin
      errors++; $display("FAIL bounce_count: got %0d want 1", cnt);
    end
    checks++;
    if (at !== 2 + DB + 1) begin
      errors++; $display("FAIL bounce_latency: got %0d want %0d", at, 2 + DB + 1);
    end
    btn_left = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bounce_drain_cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int want[$];
    for (int age = 0; age < 40; age++) begin
      if (age == 0 || (age >= RD && (age - RD) % RR == 0)) want.push_back(2 + DB + 1 + age);
    end
    core_ready = 1'b1;
    btn_down = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 40) btn_down = 1'b0;
      step();
      if (Down) got.push_back(k);
    end
    checks++;
    if (got.size() !== want.size()) begin
      errors++; $display("FAIL repeat_count: got %0d want %0d", got.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL repeat_time%0d: got %0d want %0d", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_queueing();
    int seen;
    core_ready = 1'b0;
    btn_rotate = 1'b1;
    repeat (8) step();
    btn_rotate = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen += int'(Rotate);
    end
    checks++;
    if (pending !== 4'b1000 || seen !== 0) begin
      errors++; $display("FAIL queue_hold: got pending=%b pulses=%0d want 1000/0", pending, seen);
    end
    core_ready = 1'b1;
    step();
    checks++;
    if ({Rotate, pending} !== 5'b1_0000) begin
      errors++; $display("FAIL queue_issue: got %b want %b", {Rotate, pending}, 5'b1_0000);
    end
    step();
    checks++;
    if (Rotate !== 1'b0) begin
      errors++; $display("FAIL queue_single: got %b want 0", Rotate);
    end
  endtask

  task automatic test_priority_gap();
    logic [3:0] want [8];
    logic [3:0] got;
    core_ready = 1'b0;
    btn_left = 1'b1; btn_down = 1'b1; btn_rotate = 1'b1;
    repeat (8) step();
    btn_left = 1'b0; btn_down = 1'b0; btn_rotate = 1'b0;
    repeat (8) step();
    checks++;
    if (pending !== 4'b1101) begin
      errors++; $display("FAIL prio_pending: got %b want %b", pending, 4'b1101);
    end
    for (int k = 0; k < 8; k++) want[k] = 4'b0000;
    want[0] = 4'b1000; want[2] = 4'b0010; want[4] = 4'b0001; // {L,R,D,Rot}
    core_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      got = {Left, Right, Down, Rotate};
      checks++;
      if (got !== want[k]) begin
        errors++; $display("FAIL prio_cyc%0d: got %b want %b", k, got, want[k]);
      end
    end
  endtask

  task automatic test_cancel_start();
    int nl, nr, ns, nt;
    core_ready = 1'b0;
    btn_left = 1'b1; repeat (8) step(); btn_left = 1'b0; repeat (4) step();
    checks++;
    if (pending !== 4'b0001) begin
      errors++; $display("FAIL cancel_left: got %b want %b", pending, 4'b0001);
    end
    btn_right = 1'b1; repeat (8) step(); btn_right = 1'b0; repeat (4) step();
    checks++;
    if (pending !== 4'b0010) begin
      errors++; $display("FAIL cancel_right: got %b want %b", pending, 4'b0010);
    end
    core_ready = 1'b1; nl = 0; nr = 0;
    for (int k = 0; k < 6; k++) begin
      step(); nl += int'(Left); nr += int'(Right);
    end
    checks++;
    if (nl !== 0 || nr !== 1) begin
      errors++; $display("FAIL cancel_issue: got L=%0d R=%0d want L=0 R=1", nl, nr);
    end
    core_ready = 1'b0;
    btn_left = 1'b1; btn_right = 1'b1; repeat (8) step();
    btn_left = 1'b0; btn_right = 1'b0; repeat (4) step();
    checks++;
    if (pending !== 4'b0000) begin
      errors++; $display("FAIL cancel_both: got %b want %b", pending, 4'b0000);
    end
    ns = 0; nt = 0;
    btn_start = 1'b1; btn_try_again = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 25) begin btn_start = 1'b0; btn_try_again = 1'b0; end
      step(); ns += int'(Start); nt += int'(try_again);
    end
    checks++;
    if (ns !== 1 || nt !== 1) begin
      errors++; $display("FAIL start_pulse: got start=%0d try=%0d want 1/1", ns, nt);
    end
  endtask

  task automatic test_random();
    logic [5:0] b;
    b = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
      end
      {btn_try_again, btn_start, btn_rotate, btn_down, btn_right, btn_left} = b;
      if ($urandom_range(0, 7) == 0) core_ready = ~core_ready;
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
      checks++;
      if ($countones({Left, Right, Down, Rotate}) > 1) begin
        errors++; $display("FAIL random_excl_cyc%0d: got %b want onehot0", k, {Left, Right, Down, Rotate});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    @(negedge Clk);
    test_reset();
    test_bounce();
    test_auto_repeat();
    test_queueing();
    test_priority_gap();
    test_cancel_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
